// File: rtl/axi_sram_rd_slave.sv
// AXI4 read-only responder (AR/R channels) backed by a word-addressed SRAM with a side load port.
// Optional build macro AXI_RD_RAND_DELAY_EN inserts LFSR-driven idle cycles before every beat.
module axi_sram_rd_slave #(
    parameter logic [31:0] BASE_ADDR  = 32'h0f00_0000,
    parameter int          DEPTH_LOG2 = 10,
    parameter int          LATENCY    = 2
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic [31:0]           i_axi_araddr,
    input  logic                  i_axi_arvalid,
    output logic                  o_axi_arready,
    input  logic [3:0]            i_axi_arid,
    input  logic [7:0]            i_axi_arlen,
    input  logic [2:0]            i_axi_arsize,
    input  logic [1:0]            i_axi_arburst,
    output logic [31:0]           o_axi_rdata,
    output logic                  o_axi_rvalid,
    input  logic                  i_axi_rready,
    output logic [1:0]            o_axi_rresp,
    output logic [3:0]            o_axi_rid,
    output logic                  o_axi_rlast,
    input  logic                  i_ld_en,
    input  logic [DEPTH_LOG2-1:0] i_ld_addr,
    input  logic [31:0]           i_ld_data
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic [1:0] {IDLE, WAIT, DATA} state_t;

    logic [31:0] mem [DEPTH];

    state_t      state;
    logic [31:0] addr_q;
    logic [3:0]  id_q;
    logic [7:0]  len_q;
    logic [2:0]  size_q;
    logic [1:0]  burst_q;
    logic [7:0]  beat_cnt;
    logic [7:0]  wait_cnt;

    logic        arready;
    logic        rvalid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic [3:0]  rid;
    logic        rlast;

    logic [31:0] step;
    logic [31:0] wrap_mask;
    logic [31:0] next_addr;
    logic        hs;
    logic [31:0] load_addr;
    logic [7:0]  load_beat;
    logic        wrap_len_ok;
    logic        load_err;
    logic        do_load;
    logic        gap_ok_idle;
    logic        gap_ok_hs;
    logic [DEPTH_LOG2-1:0] load_idx;
    logic        unused_bits;

`ifdef AXI_RD_RAND_DELAY_EN
    logic [7:0] lfsr;
    logic [1:0] gap_cnt;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            lfsr <= 8'hA5;
        end else begin
            lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        end
    end

    assign gap_ok_idle = (gap_cnt == 2'd0);
    assign gap_ok_hs   = (lfsr[1:0] == 2'd0);
`else
    assign gap_ok_idle = 1'b1;
    assign gap_ok_hs   = 1'b1;
`endif

    assign step      = 32'd1 << size_q;
    assign wrap_mask = (({24'd0, len_q} + 32'd1) << size_q) - 32'd1;
    assign hs        = rvalid && i_axi_rready;

    always_comb begin
        next_addr = addr_q;
        case (burst_q)
            2'b01:   next_addr = addr_q + step;
            2'b10:   next_addr = (addr_q & ~wrap_mask) | ((addr_q + step) & wrap_mask);
            default: next_addr = addr_q;
        endcase
    end

    // A beat accepted mid-burst loads its successor straight away, so the address is looked ahead.
    always_comb begin
        load_addr = addr_q;
        load_beat = beat_cnt;
        if (hs) begin
            load_addr = next_addr;
            load_beat = beat_cnt + 8'd1;
        end
    end

    assign wrap_len_ok = (len_q == 8'd1) || (len_q == 8'd3) || (len_q == 8'd7) || (len_q == 8'd15);
    assign load_err    = (load_addr[31:DEPTH_LOG2+2] != BASE_ADDR[31:DEPTH_LOG2+2])
                      || (size_q > 3'd2)
                      || (burst_q == 2'b11)
                      || ((burst_q == 2'b10) && !wrap_len_ok);
    assign load_idx    = load_addr[DEPTH_LOG2+1:2];
    assign do_load     = (state == DATA) && ((!rvalid && gap_ok_idle) || (hs && !rlast && gap_ok_hs));
    assign unused_bits = ^load_addr[1:0];

    always_ff @(posedge i_clock) begin
        if (i_ld_en) begin
            mem[i_ld_addr] <= i_ld_data;
        end
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state    <= IDLE;
            addr_q   <= '0;
            id_q     <= '0;
            len_q    <= '0;
            size_q   <= '0;
            burst_q  <= '0;
            beat_cnt <= '0;
            wait_cnt <= '0;
            arready  <= 1'b0;
            rvalid   <= 1'b0;
            rdata    <= '0;
            rresp    <= '0;
            rid      <= '0;
            rlast    <= 1'b0;
`ifdef AXI_RD_RAND_DELAY_EN
            gap_cnt  <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (arready && i_axi_arvalid) begin
                        addr_q   <= i_axi_araddr;
                        id_q     <= i_axi_arid;
                        len_q    <= i_axi_arlen;
                        size_q   <= i_axi_arsize;
                        burst_q  <= i_axi_arburst;
                        beat_cnt <= '0;
                        arready  <= 1'b0;
                        if (LATENCY > 0) begin
                            state    <= WAIT;
                            wait_cnt <= 8'(LATENCY);
                        end else begin
                            state    <= DATA;
`ifdef AXI_RD_RAND_DELAY_EN
                            gap_cnt  <= lfsr[1:0];
`endif
                        end
                    end else begin
                        arready <= 1'b1;
                    end
                end
                WAIT: begin
                    if (wait_cnt <= 8'd1) begin
                        state   <= DATA;
`ifdef AXI_RD_RAND_DELAY_EN
                        gap_cnt <= lfsr[1:0];
`endif
                    end else begin
                        wait_cnt <= wait_cnt - 8'd1;
                    end
                end
                DATA: begin
                    if (hs) begin
                        if (rlast) begin
                            rvalid  <= 1'b0;
                            rlast   <= 1'b0;
                            arready <= 1'b1;
                            state   <= IDLE;
                        end else begin
                            addr_q   <= next_addr;
                            beat_cnt <= beat_cnt + 8'd1;
`ifdef AXI_RD_RAND_DELAY_EN
                            if (lfsr[1:0] != 2'd0) begin
                                rvalid  <= 1'b0;
                                gap_cnt <= lfsr[1:0] - 2'd1;
                            end
`endif
                        end
                    end
`ifdef AXI_RD_RAND_DELAY_EN
                    else if (!rvalid && gap_cnt != 2'd0) begin
                        gap_cnt <= gap_cnt - 2'd1;
                    end
`endif
                end
                default: state <= IDLE;
            endcase

            // Beat capture reads the array before any same-edge load lands, so a colliding load is not seen.
            if (do_load) begin
                rvalid <= 1'b1;
                rdata  <= load_err ? 32'd0 : mem[load_idx];
                rresp  <= load_err ? 2'b10 : 2'b00;
                rid    <= id_q;
                rlast  <= (load_beat == len_q);
            end
        end
    end

    assign o_axi_arready = arready;
    assign o_axi_rvalid  = rvalid;
    assign o_axi_rdata   = rdata;
    assign o_axi_rresp   = rresp;
    assign o_axi_rid     = rid;
    assign o_axi_rlast   = rlast;

endmodule

// File: tb/tb_axi_sram_rd_slave.sv
// Directed testbench for axi_sram_rd_slave in its default build (fixed latency of 2).
module tb_axi_sram_rd_slave;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [3:0]  arid;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic [31:0] rdata;
    logic        rvalid;
    logic        rready;
    logic [1:0]  rresp;
    logic [3:0]  rid;
    logic        rlast;
    logic        ld_en;
    logic [9:0]  ld_addr;
    logic [31:0] ld_data;

    int vectors    = 0;
    int miscompares = 0;

    logic [31:0] got_data [16];
    logic [1:0]  got_resp [16];
    logic        got_last [16];
    logic [3:0]  got_id   [16];
    int          nbeats;
    int          first_lat;
    int          gaps;
    logic        ar_after_hs;

    axi_sram_rd_slave dut (
        .i_clock       (clock),
        .i_reset       (reset),
        .i_axi_araddr  (araddr),
        .i_axi_arvalid (arvalid),
        .o_axi_arready (arready),
        .i_axi_arid    (arid),
        .i_axi_arlen   (arlen),
        .i_axi_arsize  (arsize),
        .i_axi_arburst (arburst),
        .o_axi_rdata   (rdata),
        .o_axi_rvalid  (rvalid),
        .i_axi_rready  (rready),
        .o_axi_rresp   (rresp),
        .o_axi_rid     (rid),
        .o_axi_rlast   (rlast),
        .i_ld_en       (ld_en),
        .i_ld_addr     (ld_addr),
        .i_ld_data     (ld_data)
    );

    always #5 clock = ~clock;

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic load_word(input logic [9:0] a, input logic [31:0] d);
        ld_en   = 1'b1;
        ld_addr = a;
        ld_data = d;
        tick;
        ld_en   = 1'b0;
    endtask

    task automatic wait_arready;
        int cyc = 0;
        while (!arready && cyc < 20) begin
            tick;
            cyc++;
        end
    endtask

    task automatic send_ar(input logic [31:0] a, input logic [7:0] l, input logic [2:0] s,
                           input logic [1:0] b, input logic [3:0] i);
        wait_arready;
        araddr  = a;
        arlen   = l;
        arsize  = s;
        arburst = b;
        arid    = i;
        arvalid = 1'b1;
        tick;
        arvalid = 1'b0;
        ar_after_hs = arready;
    endtask

    // Issues one read with rready held high and records every beat plus its timing.
    task automatic run_burst(input logic [31:0] a, input logic [7:0] l, input logic [2:0] s,
                             input logic [1:0] b, input logic [3:0] i);
        int  cyc = 0;
        bit  done = 0;
        nbeats    = 0;
        first_lat = -1;
        gaps      = 0;
        rready    = 1'b1;
        send_ar(a, l, s, b, i);
        while (!done && cyc < 60) begin
            tick;
            cyc++;
            if (rvalid) begin
                if (nbeats == 0) first_lat = cyc;
                if (nbeats < 16) begin
                    got_data[nbeats] = rdata;
                    got_resp[nbeats] = rresp;
                    got_last[nbeats] = rlast;
                    got_id[nbeats]   = rid;
                end
                nbeats++;
                if (rlast) done = 1;
            end else if (nbeats > 0) begin
                gaps++;
            end
        end
        if (!done) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL burst_timeout addr=%h got %0d beats without rlast", a, nbeats);
        end
        tick;
    endtask

    task automatic test_reset;
        reset   = 1'b1;
        arvalid = 1'b0;
        rready  = 1'b0;
        ld_en   = 1'b0;
        araddr  = '0;
        arid    = '0;
        arlen   = '0;
        arsize  = '0;
        arburst = '0;
        ld_addr = '0;
        ld_data = '0;
        #22;
        vectors++;
        if ({arready, rvalid, rlast, rresp, rid, rdata} !== 41'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_outputs got ar=%b rv=%b rl=%b resp=%b id=%h data=%h want all 0",
                     arready, rvalid, rlast, rresp, rid, rdata);
        end
        reset = 1'b0;
        tick;
        vectors++;
        if (arready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL reset_arready got %b want 1", arready);
        end
    endtask

    task automatic test_single_beat;
        run_burst(32'h0f00_0014, 8'd0, 3'd2, 2'b01, 4'd3);
        vectors++;
        if (ar_after_hs !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL single_ar_drop got %b want 0", ar_after_hs);
        end
        vectors++;
        if (nbeats !== 1 || first_lat !== 3) begin
            miscompares++;
            $display("[TB] FAIL single_timing got beats=%0d lat=%0d want 1/3", nbeats, first_lat);
        end
        vectors++;
        if ({got_data[0], got_resp[0], got_id[0], got_last[0]} !== {32'hDEADBEEF, 2'b00, 4'd3, 1'b1}) begin
            miscompares++;
            $display("[TB] FAIL single_beat got data=%h resp=%b id=%h last=%b want DEADBEEF/00/3/1",
                     got_data[0], got_resp[0], got_id[0], got_last[0]);
        end
        vectors++;
        if (arready !== 1'b1 || rvalid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL single_return got ar=%b rv=%b want 1/0", arready, rvalid);
        end
    endtask

    task automatic test_line_fill;
        run_burst(32'h0f00_0008, 8'd1, 3'd2, 2'b01, 4'd5);
        vectors++;
        if (nbeats !== 2 || gaps !== 0) begin
            miscompares++;
            $display("[TB] FAIL fill_shape got beats=%0d gaps=%0d want 2/0", nbeats, gaps);
        end
        vectors++;
        if ({got_data[0], got_last[0], got_data[1], got_last[1]} !==
            {32'h11111111, 1'b0, 32'h22222222, 1'b1}) begin
            miscompares++;
            $display("[TB] FAIL fill_data got %h/%b %h/%b want 11111111/0 22222222/1",
                     got_data[0], got_last[0], got_data[1], got_last[1]);
        end
        vectors++;
        if (got_resp[0] !== 2'b00 || got_resp[1] !== 2'b00 || got_id[1] !== 4'd5) begin
            miscompares++;
            $display("[TB] FAIL fill_resp got %b %b id=%h want 00 00 5", got_resp[0], got_resp[1], got_id[1]);
        end
    endtask

    task automatic test_wrap;
        logic [31:0] exp_d [4];
        exp_d[0] = 32'h11111111;
        exp_d[1] = 32'h22222222;
        exp_d[2] = 32'hA0A0A0A0;
        exp_d[3] = 32'hB1B1B1B1;
        run_burst(32'h0f00_0008, 8'd3, 3'd2, 2'b10, 4'd7);
        vectors++;
        if (nbeats !== 4 || gaps !== 0) begin
            miscompares++;
            $display("[TB] FAIL wrap_shape got beats=%0d gaps=%0d want 4/0", nbeats, gaps);
        end
        for (int k = 0; k < 4; k++) begin
            vectors++;
            if ({got_data[k], got_resp[k], got_last[k]} !== {exp_d[k], 2'b00, (k == 3) ? 1'b1 : 1'b0}) begin
                miscompares++;
                $display("[TB] FAIL wrap_beat%0d got %h/%b/%b want %h/00/%0d",
                         k, got_data[k], got_resp[k], got_last[k], exp_d[k], (k == 3));
            end
        end
    endtask

    task automatic test_fixed;
        run_burst(32'h0f00_0014, 8'd2, 3'd2, 2'b00, 4'd9);
        vectors++;
        if (nbeats !== 3) begin
            miscompares++;
            $display("[TB] FAIL fixed_beats got %0d want 3", nbeats);
        end
        for (int k = 0; k < 3; k++) begin
            vectors++;
            if (got_data[k] !== 32'hDEADBEEF || got_resp[k] !== 2'b00) begin
                miscompares++;
                $display("[TB] FAIL fixed_beat%0d got %h/%b want DEADBEEF/00", k, got_data[k], got_resp[k]);
            end
        end
    endtask

    task automatic test_backpressure;
        int cyc = 0;
        rready = 1'b0;
        send_ar(32'h0f00_0008, 8'd1, 3'd2, 2'b01, 4'd1);
        while (!rvalid && cyc < 20) begin
            tick;
            cyc++;
        end
        vectors++;
        if (rvalid !== 1'b1 || rdata !== 32'h11111111) begin
            miscompares++;
            $display("[TB] FAIL bp_first got rv=%b data=%h want 1/11111111", rvalid, rdata);
        end
        for (int k = 0; k < 3; k++) begin
            tick;
            vectors++;
            if (rvalid !== 1'b1 || rdata !== 32'h11111111 || rlast !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL bp_hold%0d got rv=%b data=%h last=%b want 1/11111111/0",
                         k, rvalid, rdata, rlast);
            end
        end
        rready = 1'b1;
        tick;
        vectors++;
        if (rvalid !== 1'b1 || rdata !== 32'h22222222 || rlast !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL bp_second got rv=%b data=%h last=%b want 1/22222222/1", rvalid, rdata, rlast);
        end
        tick;
        vectors++;
        if (rvalid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL bp_done got rv=%b want 0", rvalid);
        end
    endtask

    task automatic test_errors;
        run_burst(32'h8000_0000, 8'd0, 3'd2, 2'b01, 4'd2);
        vectors++;
        if (nbeats !== 1 || got_resp[0] !== 2'b10 || got_data[0] !== 32'd0 || got_last[0] !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL err_range got beats=%0d resp=%b data=%h last=%b want 1/10/0/1",
                     nbeats, got_resp[0], got_data[0], got_last[0]);
        end
        run_burst(32'h0f00_0ffc, 8'd1, 3'd2, 2'b01, 4'd4);
        vectors++;
        if (nbeats !== 2 || got_resp[0] !== 2'b00 || got_data[0] !== 32'hCAFEF00D) begin
            miscompares++;
            $display("[TB] FAIL err_edge_beat0 got beats=%0d resp=%b data=%h want 2/00/CAFEF00D",
                     nbeats, got_resp[0], got_data[0]);
        end
        vectors++;
        if (got_resp[1] !== 2'b10 || got_data[1] !== 32'd0 || got_last[1] !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL err_edge_beat1 got resp=%b data=%h last=%b want 10/0/1",
                     got_resp[1], got_data[1], got_last[1]);
        end
        run_burst(32'h0f00_0008, 8'd1, 3'd3, 2'b01, 4'd6);
        vectors++;
        if (nbeats !== 2 || {got_resp[0], got_resp[1]} !== 4'b1010 || {got_data[0], got_data[1]} !== 64'd0) begin
            miscompares++;
            $display("[TB] FAIL err_size got beats=%0d resp=%b %b data=%h %h want 2/10 10/0 0",
                     nbeats, got_resp[0], got_resp[1], got_data[0], got_data[1]);
        end
        run_burst(32'h0f00_0008, 8'd2, 3'd2, 2'b10, 4'd8);
        vectors++;
        if (nbeats !== 3 || {got_resp[0], got_resp[1], got_resp[2]} !== 6'b101010) begin
            miscompares++;
            $display("[TB] FAIL err_wrap_len got beats=%0d resp=%b %b %b want 3/10 10 10",
                     nbeats, got_resp[0], got_resp[1], got_resp[2]);
        end
    endtask

    task automatic test_load_collision;
        rready = 1'b1;
        send_ar(32'h0f00_001c, 8'd0, 3'd2, 2'b01, 4'd2);
        tick;
        tick;
        ld_en   = 1'b1;
        ld_addr = 10'd7;
        ld_data = 32'hAAAAAAAA;
        tick;
        ld_en = 1'b0;
        vectors++;
        if (rvalid !== 1'b1 || rdata !== 32'h77777777) begin
            miscompares++;
            $display("[TB] FAIL collide_old got rv=%b data=%h want 1/77777777", rvalid, rdata);
        end
        tick;
        run_burst(32'h0f00_001c, 8'd0, 3'd2, 2'b01, 4'd2);
        vectors++;
        if (got_data[0] !== 32'hAAAAAAAA) begin
            miscompares++;
            $display("[TB] FAIL collide_new got %h want AAAAAAAA", got_data[0]);
        end
    endtask

    task automatic test_reset_mid_burst;
        int cyc = 0;
        rready = 1'b1;
        send_ar(32'h0f00_0000, 8'd3, 3'd2, 2'b01, 4'd1);
        while (!rvalid && cyc < 20) begin
            tick;
            cyc++;
        end
        tick;
        vectors++;
        if (rvalid !== 1'b1 || rdata !== 32'hB1B1B1B1) begin
            miscompares++;
            $display("[TB] FAIL midrst_beat1 got rv=%b data=%h want 1/B1B1B1B1", rvalid, rdata);
        end
        reset = 1'b1;
        #1;
        vectors++;
        if ({arready, rvalid, rlast, rresp, rid, rdata} !== 41'd0) begin
            miscompares++;
            $display("[TB] FAIL midrst_clear got ar=%b rv=%b rl=%b resp=%b id=%h data=%h want all 0",
                     arready, rvalid, rlast, rresp, rid, rdata);
        end
        #1;
        reset = 1'b0;
        tick;
        vectors++;
        if (arready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL midrst_arready got %b want 1", arready);
        end
        run_burst(32'h0f00_0014, 8'd0, 3'd2, 2'b01, 4'd3);
        vectors++;
        if (nbeats !== 1 || got_data[0] !== 32'hDEADBEEF || got_resp[0] !== 2'b00 || got_last[0] !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL midrst_after got beats=%0d data=%h resp=%b last=%b want 1/DEADBEEF/00/1",
                     nbeats, got_data[0], got_resp[0], got_last[0]);
        end
    endtask

    initial begin
        test_reset;
        load_word(10'd0,    32'hA0A0A0A0);
        load_word(10'd1,    32'hB1B1B1B1);
        load_word(10'd2,    32'h11111111);
        load_word(10'd3,    32'h22222222);
        load_word(10'd5,    32'hDEADBEEF);
        load_word(10'd7,    32'h77777777);
        load_word(10'd1023, 32'hCAFEF00D);
        test_single_beat;
        test_line_fill;
        test_wrap;
        test_fixed;
        test_backpressure;
        test_errors;
        test_load_collision;
        test_reset_mid_burst;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/axi_sram_rd_slave.md
Name: axi_sram_rd_slave

Overview:
AXI4 read-channel responder (AR/R only) backed by a word-addressed on-chip SRAM array. It serves the fetch side: the instruction cache issues 2-beat line fills, and direct uncached fetches issue single beats into the 0x0f00_0000 window. One outstanding transaction at a time. A side load port preloads contents from the bench or a boot loader.

Parameters:
BASE_ADDR, 32'h0f00_0000, byte base of the array; must be aligned to 4<<DEPTH_LOG2
DEPTH_LOG2, 10, log2 of word count (1024 words = 4 KiB)
LATENCY, 2, extra cycles between AR handshake and first beat (0 allowed)

Ports:
i_clock  in  1  clock
i_reset  in  1  asynchronous reset, active-high
i_axi_araddr  in  32  read address
i_axi_arvalid  in  1  AR valid
o_axi_arready  out  1  AR ready
i_axi_arid  in  4  transaction id
i_axi_arlen  in  8  beats minus 1
i_axi_arsize  in  3  bytes per beat, log2
i_axi_arburst  in  2  00 FIXED, 01 INCR, 10 WRAP
o_axi_rdata  out  32  read data
o_axi_rvalid  out  1  R valid
i_axi_rready  in  1  R ready
o_axi_rresp  out  2  00 OKAY, 10 SLVERR
o_axi_rid  out  4  echoed arid
o_axi_rlast  out  1  last beat
i_ld_en  in  1  load-port write strobe
i_ld_addr  in  DEPTH_LOG2  word index
i_ld_data  in  32  load data

Behaviour:
- Reset: clock is i_clock. Reset is i_reset, asynchronous and active-high. While reset is asserted, all outputs are 0: arready, rvalid, rlast, rresp, rid, rdata. Memory contents are not reset.
- States: IDLE, WAIT, DATA.
- IDLE:
  - o_axi_arready=1 from the first cycle after reset release.
  - On arvalid&&arready, latch addr, id, len, size and burst, clear the beat counter (8 bits) and drop arready.
  - Go to WAIT if LATENCY>0, else DATA.
- WAIT: count down LATENCY cycles, then enter DATA.
- Timing: for an AR handshake at edge T, the first rvalid is high in cycle T+1+LATENCY.
- DATA:
  - Present a beat with rvalid=1.
  - rdata, rresp, rid and rlast hold stable while rvalid&&!rready.
  - On rready, if this is not the last beat, present the next beat in the following cycle with no gap.
  - rlast=1 only when the beat counter equals len.
  - On the last handshake, go to IDLE; arready=1 in the next cycle.
- Beat address:
  - FIXED: constant.
  - INCR: addr += 1<<size.
  - WRAP: wrap within an aligned block of (len+1)<<size bytes. Legal len values are 1, 3, 7 and 15; any other len gives SLVERR.
- Data lanes:
  - Word index = addr[DEPTH_LOG2+1:2].
  - The full aligned word is returned regardless of size or addr[1:0]; the master selects lanes.
- SLVERR, per beat with rdata=0, when any of these hold:
  - addr[31:DEPTH_LOG2+2] != BASE_ADDR[31:DEPTH_LOG2+2];
  - size>2;
  - burst==11;
  - an illegal WRAP len.
- Out-of-range handling: a burst that crosses out of range mid-way errors only on the out-of-range beats. The burst always completes the full len+1 beats.
- rdata capture: rdata is registered from the array when a beat is loaded.
- Load port:
  - i_ld_en writes on the clock edge and is accepted in any state.
  - A load to the word being captured at the same edge is not visible in that beat (old data returned).
- Backpressure: arvalid during WAIT or DATA is ignored (arready=0) and must be held by the master.
- Reset mid-burst: outputs clear immediately and the block returns to IDLE. There is no partial-burst completion.

Optional Feature:
AXI_RD_RAND_DELAY_EN:
- Defined:
  - An 8-bit Fibonacci LFSR (taps 8,6,5,4; seed 8'hA5 on reset) advances every cycle.
  - Before each beat, including the first after WAIT, insert lfsr[1:0] cycles with rvalid=0.
  - Handshake rules are unchanged, and rvalid never drops once asserted until accepted.
- Undefined: fixed timing as above and no LFSR logic.

Test Plan:
- Single beat: load word 5=32'hDEADBEEF; AR addr=0x0f000014, len=0, size=2, burst=01, id=3 -> one beat in cycle T+3 with rdata DEADBEEF, rresp 00, rid 3, rlast=1; arready back 1 the cycle after acceptance.
- Icache line fill: words 2,3=0x11111111,0x22222222; AR addr=0x0f000008, len=1, INCR, rready=1 -> consecutive beats 11111111 then 22222222 (rlast on second), no gap.
- WRAP: AR addr=0x0f000008, len=3, burst=10 -> beats from words 2,3,0,1; rlast on the 4th beat.
- Backpressure: rready low for 3 cycles during beat 0 of a 2-beat burst -> rvalid and rdata held unchanged; beat 1 follows one cycle after acceptance.
- Error paths:
  - AR addr=0x80000000 -> rresp 10, rdata 0.
  - INCR len=1 starting at the last in-range word -> beat 0 OKAY, beat 1 SLVERR.
  - size=3 -> SLVERR on all beats.
- Reset mid-burst: assert i_reset during beat 1 of a len=3 burst -> rvalid and rlast drop with no clock edge; after release, arready=1 and a new single-beat read completes normally.
